cdb_arbiter: RTL and testbench

//   Shares the single common data bus (CDB) between NUM_FU functional units.

---
 rtl/cdb_arbiter_if.sv | 38 +++
 rtl/cdb_arbiter.sv | 108 ++++++++++
 tb/tb_cdb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : cdb_arbiter_if
// Description : Bundle of FU completion requests, grants and CDB broadcast
//               signals shared between the functional units and the arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic                     flush;
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU*TAG_W-1:0]  fu_rob_tag;
  logic [NUM_FU*DATA_W-1:0] fu_data;
  logic [NUM_FU*DATA_W-1:0] fu_target_pc;
  logic [NUM_FU-1:0]        fu_mispredict;
  logic [NUM_FU-1:0]        fu_ready;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_rob_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [DATA_W-1:0]        cdb_target_pc;
  logic                     cdb_mispredict;

  // FU/ROB side: drives requests and flush, receives grants and broadcasts
  modport master (
    output flush, fu_valid, fu_rob_tag, fu_data, fu_target_pc, fu_mispredict,
    input  fu_ready, cdb_valid, cdb_rob_tag, cdb_data, cdb_target_pc, cdb_mispredict
  );

  // Arbiter side
  modport slave (
    input  flush, fu_valid, fu_rob_tag, fu_data, fu_target_pc, fu_mispredict,
    output fu_ready, cdb_valid, cdb_rob_tag, cdb_data, cdb_target_pc, cdb_mispredict
  );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : cdb_arbiter
// Description : Round-robin arbiter granting one completing FU per cycle onto
//               the registered common data bus; flush kills pending grants.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  cdb_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_win;
  logic              w_found;
  logic              w_xfer;
  logic [NUM_FU-1:0] w_grant;

  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] w_pc;
  logic              w_mp;

  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_pc;
  logic              r_mp;

  // Scan requesters starting at the round-robin pointer; index arithmetic
  // wraps naturally because NUM_FU is a power of two.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_idx = r_rr_ptr + PTR_W'(k);
      if (!w_found && bus.fu_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // One-hot grant, suppressed during reset and flush so nothing is consumed
  always_comb begin
    w_grant = '0;
    w_xfer  = w_found & ~reset & ~bus.flush;
    if (w_xfer) begin
      w_grant[w_win] = 1'b1;
    end
  end

  // Payload mux for the winning FU
  always_comb begin
    w_tag  = '0;
    w_data = '0;
    w_pc   = '0;
    w_mp   = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_tag  = bus.fu_rob_tag[i*TAG_W +: TAG_W];
        w_data = bus.fu_data[i*DATA_W +: DATA_W];
        w_pc   = bus.fu_target_pc[i*DATA_W +: DATA_W];
        w_mp   = bus.fu_mispredict[i];
      end
    end
  end

  // Pointer and broadcast register; payload holds when nothing transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_data   <= '0;
      r_pc     <= '0;
      r_mp     <= 1'b0;
    end else if (bus.flush) begin
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_rr_ptr <= w_win + PTR_W'(1);
        r_tag    <= w_tag;
        r_data   <= w_data;
        r_pc     <= w_pc;
        r_mp     <= w_mp;
      end
    end
  end

  assign bus.fu_ready       = w_grant;
  assign bus.cdb_valid      = r_valid;
  assign bus.cdb_rob_tag    = r_tag;
  assign bus.cdb_data       = r_data;
  assign bus.cdb_target_pc  = r_pc;
  assign bus.cdb_mispredict = r_mp;
endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter with a queue-free
//               behavioural model of round-robin arbitration.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cdb_arbiter;
  localparam int N      = 4;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush_in;

  logic [N-1:0]      v;
  logic [TAG_W-1:0]  tag  [N];
  logic [DATA_W-1:0] data [N];
  logic [DATA_W-1:0] pc   [N];
  logic [N-1:0]      mp;

  // reference model state
  int                m_ptr;
  logic              m_valid;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_pc;
  logic              m_mp;

  int checks = 0;
  int errors = 0;

  cdb_arbiter_if #(.NUM_FU(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.NUM_FU(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // expected grant: first valid FU found walking from the pointer
  function automatic logic [N-1:0] ref_grant();
    logic [N-1:0] g;
    g = '0;
    if (!reset && !flush_in) begin
      for (int k = 0; k < N; k++) begin
        if (g == '0 && v[(m_ptr + k) % N]) g[(m_ptr + k) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  // apply stimulus at the falling edge, settle, ready for sampling
  task automatic drive();
    @(negedge clk);
    bus.flush    = flush_in;
    bus.fu_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.fu_rob_tag[i*TAG_W +: TAG_W]    = tag[i];
      bus.fu_data[i*DATA_W +: DATA_W]     = data[i];
      bus.fu_target_pc[i*DATA_W +: DATA_W] = pc[i];
    end
    bus.fu_mispredict = mp;
    #1;
  endtask

  // cross the rising edge and update the model the way the ROB would see it
  task automatic advance();
    logic [N-1:0] g;
    g = ref_grant();
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_pc = '0; m_mp = 0;
    end else if (flush_in) begin
      m_ptr = 0; m_valid = 0;
    end else if (g != '0) begin
      for (int j = 0; j < N; j++) begin
        if (g[j]) begin
          m_valid = 1; m_tag = tag[j]; m_data = data[j]; m_pc = pc[j]; m_mp = mp[j];
          m_ptr = (j + 1) % N;
        end
      end
    end else begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; flush_in = 0; v = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      drive();
      checks++;
      if (bus.fu_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready got=%b exp=0000", bus.fu_ready);
      end
      advance();
      checks++;
      if ({bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_data, bus.cdb_target_pc, bus.cdb_mispredict} !== '0) begin
        errors++; $display("FAIL reset_cdb got valid=%b tag=%h data=%h pc=%h mp=%b exp all zero",
                           bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_data, bus.cdb_target_pc, bus.cdb_mispredict);
      end
    end
    reset = 0;
  endtask

  task automatic test_single();
    v = 4'b0100; tag[2] = 5'd3; data[2] = 32'hDEAD_BEEF;
    drive();
    checks++;
    if (bus.fu_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got=%b exp=0100", bus.fu_ready);
    end
    advance();
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== 5'd3 || bus.cdb_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_cdb got valid=%b tag=%0d data=%h exp 1/3/deadbeef",
                         bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_data);
    end
    // pointer now sits at 3
    v = 4'b1111; tag[3] = 5'd21;
    drive();
    checks++;
    if (bus.fu_ready !== 4'b1000) begin
      errors++; $display("FAIL single_ptr got=%b exp=1000", bus.fu_ready);
    end
    advance();
    checks++;
    if (bus.cdb_rob_tag !== 5'd21) begin
      errors++; $display("FAIL single_ptr_tag got=%0d exp=21", bus.cdb_rob_tag);
    end
  endtask

  task automatic test_round_robin();
    v = 4'b1111;
    for (int i = 0; i < N; i++) tag[i] = TAG_W'(i + 8);
    for (int i = 0; i < N; i++) begin
      drive();
      checks++;
      if (bus.fu_ready !== (4'b0001 << i)) begin
        errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, bus.fu_ready, 4'b0001 << i);
      end
      advance();
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== TAG_W'(i + 8)) begin
        errors++; $display("FAIL rr_tag%0d got valid=%b tag=%0d exp 1/%0d", i, bus.cdb_valid, bus.cdb_rob_tag, i + 8);
      end
    end
    drive();
    checks++;
    if (bus.fu_ready !== 4'b0001) begin
      errors++; $display("FAIL rr_wrap got=%b exp=0001", bus.fu_ready);
    end
    advance();
  endtask

  task automatic test_fairness();
    logic [N-1:0] prev;
    bit           got2;
    v = 4'b0001;
    drive(); advance();
    v = 4'b0101;
    got2 = 0;
    for (int c = 0; c < 2 && !got2; c++) begin
      drive();
      checks++;
      if (bus.fu_ready !== ref_grant()) begin
        errors++; $display("FAIL fair_grant got=%b exp=%b", bus.fu_ready, ref_grant());
      end
      got2 = bus.fu_ready[2];
      prev = bus.fu_ready;
      advance();
    end
    checks++;
    if (!got2) begin
      errors++; $display("FAIL fair_timeout got=not granted exp=FU2 within 2 cycles");
    end
    for (int c = 0; c < 6; c++) begin
      drive();
      checks++;
      if (bus.fu_ready === prev || (bus.fu_ready !== 4'b0001 && bus.fu_ready !== 4'b0100)) begin
        errors++; $display("FAIL fair_alternate got=%b prev=%b exp the other of 0001/0100", bus.fu_ready, prev);
      end
      prev = bus.fu_ready;
      advance();
    end
  endtask

  task automatic test_flush();
    v = 4'b0011; flush_in = 1;
    tag[0] = 5'd17; tag[1] = 5'd18;
    drive();
    checks++;
    if (bus.fu_ready !== 4'b0000 || bus.cdb_valid !== 1'b1) begin
      errors++; $display("FAIL flush_cycle got ready=%b cdb_valid=%b exp 0000/1", bus.fu_ready, bus.cdb_valid);
    end
    advance();
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_next got cdb_valid=%b exp=0", bus.cdb_valid);
    end
    flush_in = 0;
    drive();
    checks++;
    if (bus.fu_ready !== 4'b0001) begin
      errors++; $display("FAIL flush_ptr got=%b exp=0001", bus.fu_ready);
    end
    advance();
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== 5'd17) begin
      errors++; $display("FAIL flush_after got valid=%b tag=%0d exp 1/17", bus.cdb_valid, bus.cdb_rob_tag);
    end
  endtask

  task automatic test_mispredict();
    v = 4'b0010; tag[1] = 5'd7; pc[1] = 32'h0000_1000; mp = 4'b0010;
    drive(); advance();
    checks++;
    if (bus.cdb_mispredict !== 1'b1 || bus.cdb_target_pc !== 32'h0000_1000 || bus.cdb_rob_tag !== 5'd7) begin
      errors++; $display("FAIL mispredict got mp=%b pc=%h tag=%0d exp 1/00001000/7",
                         bus.cdb_mispredict, bus.cdb_target_pc, bus.cdb_rob_tag);
    end
    mp = '0; v = '0;
    drive(); advance();
    checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_mispredict !== 1'b1 || bus.cdb_target_pc !== 32'h0000_1000) begin
      errors++; $display("FAIL idle_hold got valid=%b mp=%b pc=%h exp 0/1/00001000",
                         bus.cdb_valid, bus.cdb_mispredict, bus.cdb_target_pc);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] granted;
    granted = '0;
    for (int c = 0; c < 400; c++) begin
      // losers keep their request and payload; others may change freely
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !granted[i])) begin
          v[i]    = ($urandom_range(0, 2) != 0);
          tag[i]  = TAG_W'($urandom);
          data[i] = $urandom;
          pc[i]   = $urandom;
          mp[i]   = $urandom_range(0, 1) == 1;
        end
      end
      reset    = ($urandom_range(0, 39) == 0);
      flush_in = ($urandom_range(0, 11) == 0);
      drive();
      checks++;
      if (bus.fu_ready !== ref_grant()) begin
        errors++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, bus.fu_ready, ref_grant());
      end
      granted = bus.fu_ready;
      advance();
      checks++;
      if ({bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_data, bus.cdb_target_pc, bus.cdb_mispredict} !==
          {m_valid, m_tag, m_data, m_pc, m_mp}) begin
        errors++; $display("FAIL rand_cdb cyc=%0d got %b/%h/%h/%h/%b exp %b/%h/%h/%h/%b", c,
                           bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_data, bus.cdb_target_pc, bus.cdb_mispredict,
                           m_valid, m_tag, m_data, m_pc, m_mp);
      end
    end
    reset = 0; flush_in = 0;
  endtask

  initial begin
    reset = 1; flush_in = 0; v = '0; mp = '0;
    for (int i = 0; i < N; i++) begin
      tag[i] = '0; data[i] = '0; pc[i] = '0;
    end
    m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_pc = '0; m_mp = 0;
    bus.flush = 0; bus.fu_valid = '0; bus.fu_rob_tag = '0; bus.fu_data = '0;
    bus.fu_target_pc = '0; bus.fu_mispredict = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_flush();
    test_mispredict();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
